bsg_mcl_fifo_serdes: RTL
========================

# bsg_mcl_fifo_serdes

Multi-channel bridge between 128-bit manycore-link records (`bsg_mcl_request_s`/`bsg_mcl_response_s`) and a narrower host FIFO of width `fifo_width_p`. The TX path round-robin arbitrates `num_chan_p` record streams, serializes each record into beats, and tags each beat with a channel id and a last flag. The RX path deserializes tagged beats back into records and routes them to the owning channel. It sits between the per-endpoint manycore-to-FIFO adapters and the shared host FIFO/DMA shell.

## Interface
Parameters:
- `num_chan_p`, 4: number of record channels, 1..16.
- `fifo_width_p`, 32: host beat width; must be 32, 64 or 128.
- `record_width_lp`, 128 (localparam): width of one record.
- `beats_lp`, `record_width_lp/fifo_width_p` (localparam): beats per record.
- `chan_width_lp`, `` `BSG_SAFE_CLOG2(num_chan_p) `` (localparam): width of the channel id.

Ports:
- `clk_i` in 1: the single clock.
- `reset_n_i` in 1: reset, asynchronous, active-low.
- `rec_v_i` in [num_chan_p]: TX record valid, one bit per channel.
- `rec_data_i` in [num_chan_p][128]: TX records.
- `rec_rdy_o` out [num_chan_p]: TX record accepted.
- `tx_v_o` out 1: host beat valid.
- `tx_data_o` out fifo_width_p: host beat data.
- `tx_chan_o` out chan_width_lp: channel id of the beat.
- `tx_last_o` out 1: final beat of a record.
- `tx_rdy_i` in 1: host ready.
- `rx_v_i` in 1: host beat valid.
- `rx_data_i` in fifo_width_p: host beat data.
- `rx_chan_i` in chan_width_lp: channel id of the beat.
- `rx_last_i` in 1: final beat of a record.
- `rx_rdy_o` out 1: RX beat accepted.
- `rec_v_o` out [num_chan_p]: RX record valid (one-hot or zero).
- `rec_data_o` out 128: RX record, shared by all channels.
- `rec_rdy_i` in [num_chan_p]: RX channel ready.
- `rx_err_o` out 1: one-cycle pulse when a malformed RX record is dropped.

## Operation
- Handshakes are valid/ready; a transfer occurs when both are high in the same cycle. Once asserted, a valid must not drop until its transfer.
- TX FSM, `T_IDLE` to `T_SEND`:
  - In `T_IDLE`, a round-robin arbiter picks among `rec_v_i`. Priority starts at the channel after the last grant; the pointer resets to channel 0.
  - The granted `rec_rdy_o` is asserted combinationally in `T_IDLE`. The record is loaded into the shift register, the channel is latched, the beat counter is cleared, and the FSM goes to `T_SEND`.
  - In `T_SEND`, `tx_v_o` is 1. `tx_data_o` is the low `fifo_width_p` bits of the shift register, so beats go LSB first. On each transfer the register shifts right by `fifo_width_p` and the counter increments.
  - `tx_last_o` = (counter == `beats_lp`-1).
  - A transfer with `tx_last_o` returns the FSM to `T_IDLE`. `rec_rdy_o` is 0 in `T_SEND`.
- RX FSM, `R_COLLECT` to `R_DELIVER`:
  - In `R_COLLECT`, `rx_rdy_o` is 1. Each accepted beat is written to slice [counter] of the record buffer.
  - The first beat latches `rx_chan_i`.
  - A packet is malformed if any of these occur:
    - `rx_last_i` is 1 before counter == `beats_lp`-1;
    - `rx_last_i` is 0 at counter == `beats_lp`-1;
    - `rx_chan_i` differs from the latched id on a later beat;
    - `rx_chan_i` >= `num_chan_p`.
  - On a malformed packet: pulse `rx_err_o` next cycle, clear the counter, stay in `R_COLLECT`, and discard the partial record.
  - A well-formed final beat moves the FSM to `R_DELIVER`.
  - In `R_DELIVER`, `rx_rdy_o` is 0, `rec_v_o[chan]` is 1 and `rec_data_o` is the buffer. When `rec_rdy_i[chan]` is seen, the FSM returns to `R_COLLECT`.
- When `beats_lp`==1, every beat is a complete record and `tx_last_o` is constantly 1 in `T_SEND`.
- The TX and RX paths are fully independent; simultaneous activity on both has no interaction.

## Timing
- Reset values: all FSMs in IDLE/COLLECT, counters 0, arbiter pointer 0.
  - `tx_v_o`=0, `tx_data_o`=0, `tx_chan_o`=0, `tx_last_o`=0.
  - `rec_v_o`=0, `rec_data_o`=0, `rx_err_o`=0.
  - `rx_rdy_o`=1 from the first clock edge after deassertion.
  - `rec_rdy_o` follows `rec_v_i` via arbitration once out of reset.
- TX latency: the record is accepted in cycle N and the first beat is valid in cycle N+1. With `tx_rdy_i` held high, the record takes `beats_lp` beats, then 1 idle cycle before the next acceptance. Throughput is `beats_lp`/(`beats_lp`+1).
- RX latency: the final beat is accepted in cycle N and `rec_v_o` is valid in cycle N+1. `rx_rdy_o` reasserts in the cycle after the record is taken.
- Assertion of `reset_n_i` mid-packet immediately (asynchronously) returns both FSMs to reset state; partial records are lost.
- Host backpressure (`tx_rdy_i`=0) holds `tx_data_o`, `tx_chan_o` and `tx_last_o` stable.

## Configuration
- `BSG_MCL_SERDES_STATS_EN` defined adds output ports:
  - `tx_rec_count_o` 32 bits, `rx_rec_count_o` 32 bits, `rx_err_count_o` 16 bits;
  - all reset to 0 and saturate at all-ones;
  - they count completed TX records, delivered RX records and dropped RX records.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

## Structure
- Shared package `bsg_mcl_serdes_pkg` holds:
  - `record_width_gp` = 128;
  - the FSM state enums `tx_state_e` and `rx_state_e`.
- `bsg_mcl_request_s` and `bsg_mcl_response_s` stay in `axil_to_mcl.vh`.
- One sub-module, `bsg_mcl_serdes_rr_arb`, is a parametrised round-robin arbiter with a grant-on-yumi pointer update.

## Test plan
- `fifo_width_p`=32, channel 2 sends 0x0123…CDEF, `tx_rdy_i`=1 -> beats 0x89ABCDEF first, 4 beats, `tx_chan_o`=2, `tx_last_o` high only on beat 3, `rec_rdy_o[2]` high for 1 cycle.
- All 4 channels valid continuously -> grant order 0,1,2,3,0, and each record occupies 5 cycles.
- RX 4 beats on channel 1 with `rec_rdy_i[1]`=0 for 10 cycles -> `rec_v_o`=4'b0010 held, `rx_rdy_o`=0, record delivered intact when ready rises.
- RX `rx_last_i`=1 on beat 2, or channel changes on beat 1 -> `rx_err_o` pulse, no `rec_v_o`, the next well-formed record is delivered correctly.
- `fifo_width_p`=128 -> single beat with `tx_last_o`=1; `tx_rdy_i` toggling 0/1 keeps data stable while stalled.
- `reset_n_i` asserted mid-TX (beat 2 of 4) -> `tx_v_o`=0 immediately; with STATS_EN, counters read 0 after reset.

Source files
------------

// File: rtl/bsg_mcl_serdes_pkg.sv
// Shared constants, FSM state types and width helper for the manycore-link FIFO serdes.
package bsg_mcl_serdes_pkg;

    localparam int record_width_gp = 128;

    typedef enum logic {
        T_IDLE = 1'b0,
        T_SEND = 1'b1
    } tx_state_e;

    typedef enum logic {
        R_COLLECT = 1'b0,
        R_DELIVER = 1'b1
    } rx_state_e;

    // Never returns 0, so a 1-entry selector still gets a 1-bit field.
    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bsg_mcl_serdes_rr_arb.sv
// Round-robin arbiter: priority starts one past the last granted requester,
// and the pointer only advances when the grant is actually consumed (yumi).
module bsg_mcl_serdes_rr_arb
    import bsg_mcl_serdes_pkg::*;
#(
    parameter int width_p = 4,
    localparam int idx_width_lp = safe_clog2(width_p)
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic [width_p-1:0]      reqs_i,
    input  logic                    yumi_i,
    output logic                    v_o,
    output logic [width_p-1:0]      grants_o,
    output logic [idx_width_lp-1:0] grant_id_o
);

    logic [idx_width_lp-1:0] ptr_q, ptr_d;
    logic                    hi_found, lo_found;
    logic [idx_width_lp-1:0] hi_id, lo_id;

    // Lowest requester at or above the pointer wins; otherwise wrap to the lowest overall.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_id    = '0;
        lo_id    = '0;
        for (int i = width_p - 1; i >= 0; i--) begin
            if (reqs_i[i] && (i >= int'(ptr_q))) begin
                hi_found = 1'b1;
                hi_id    = idx_width_lp'(i);
            end
            if (reqs_i[i]) begin
                lo_found = 1'b1;
                lo_id    = idx_width_lp'(i);
            end
        end
    end

    assign v_o        = lo_found;
    assign grant_id_o = hi_found ? hi_id : lo_id;

    always_comb begin
        grants_o = '0;
        for (int i = 0; i < width_p; i++) begin
            grants_o[i] = v_o && (int'(grant_id_o) == i);
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (yumi_i && v_o) begin
            if (grant_id_o == idx_width_lp'(width_p - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_id_o + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/bsg_mcl_fifo_serdes.sv
// Bridges num_chan_p 128-bit manycore-link record streams onto one tagged host
// FIFO (TX: arbitrate + serialize, RX: deserialize + route).
// Define BSG_MCL_SERDES_STATS_EN to add saturating record/error counters.
module bsg_mcl_fifo_serdes
    import bsg_mcl_serdes_pkg::*;
#(
    parameter int num_chan_p   = 4,
    parameter int fifo_width_p = 32,
    localparam int record_width_lp = record_width_gp,
    localparam int beats_lp        = record_width_lp / fifo_width_p,
    localparam int chan_width_lp   = safe_clog2(num_chan_p)
) (
    input  logic                                          clk_i,
    input  logic                                          reset_n_i,

    input  logic [num_chan_p-1:0]                         rec_v_i,
    input  logic [num_chan_p-1:0][record_width_lp-1:0]    rec_data_i,
    output logic [num_chan_p-1:0]                         rec_rdy_o,

    output logic                                          tx_v_o,
    output logic [fifo_width_p-1:0]                       tx_data_o,
    output logic [chan_width_lp-1:0]                      tx_chan_o,
    output logic                                          tx_last_o,
    input  logic                                          tx_rdy_i,

    input  logic                                          rx_v_i,
    input  logic [fifo_width_p-1:0]                       rx_data_i,
    input  logic [chan_width_lp-1:0]                      rx_chan_i,
    input  logic                                          rx_last_i,
    output logic                                          rx_rdy_o,

    output logic [num_chan_p-1:0]                         rec_v_o,
    output logic [record_width_lp-1:0]                    rec_data_o,
    input  logic [num_chan_p-1:0]                         rec_rdy_i,
    output logic                                          rx_err_o
`ifdef BSG_MCL_SERDES_STATS_EN
    ,
    output logic [31:0]                                   tx_rec_count_o,
    output logic [31:0]                                   rx_rec_count_o,
    output logic [15:0]                                   rx_err_count_o
`endif
);

    localparam int cnt_width_lp = safe_clog2(beats_lp);
    localparam logic [cnt_width_lp-1:0] last_cnt_lp = cnt_width_lp'(beats_lp - 1);

    // ---------------- TX: arbitrate, load, shift out LSB first ----------------
    tx_state_e                  tx_state_q, tx_state_d;
    logic [record_width_lp-1:0] tx_shift_q, tx_shift_d;
    logic [chan_width_lp-1:0]   tx_chan_q, tx_chan_d;
    logic [cnt_width_lp-1:0]    tx_cnt_q, tx_cnt_d;

    logic                       arb_v, arb_yumi;
    logic [num_chan_p-1:0]      arb_grants;
    logic [chan_width_lp-1:0]   arb_id;
    logic                       tx_fire, tx_at_last, tx_done;

    bsg_mcl_serdes_rr_arb #(
        .width_p (num_chan_p)
    ) u_arb (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .reqs_i     (rec_v_i),
        .yumi_i     (arb_yumi),
        .v_o        (arb_v),
        .grants_o   (arb_grants),
        .grant_id_o (arb_id)
    );

    assign arb_yumi   = (tx_state_q == T_IDLE) && arb_v;
    assign rec_rdy_o  = (tx_state_q == T_IDLE) ? arb_grants : '0;

    assign tx_v_o     = (tx_state_q == T_SEND);
    assign tx_data_o  = tx_shift_q[fifo_width_p-1:0];
    assign tx_chan_o  = tx_chan_q;
    assign tx_at_last = (tx_cnt_q == last_cnt_lp);
    assign tx_last_o  = tx_v_o && tx_at_last;
    assign tx_fire    = tx_v_o && tx_rdy_i;
    assign tx_done    = tx_fire && tx_at_last;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_shift_d = tx_shift_q;
        tx_chan_d  = tx_chan_q;
        tx_cnt_d   = tx_cnt_q;
        unique case (tx_state_q)
            T_IDLE: begin
                if (arb_v) begin
                    tx_shift_d = rec_data_i[arb_id];
                    tx_chan_d  = arb_id;
                    tx_cnt_d   = '0;
                    tx_state_d = T_SEND;
                end
            end
            T_SEND: begin
                if (tx_fire) begin
                    tx_shift_d = tx_shift_q >> fifo_width_p;
                    if (tx_at_last) begin
                        tx_cnt_d   = '0;
                        tx_state_d = T_IDLE;
                    end else begin
                        tx_cnt_d = tx_cnt_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            tx_state_q <= T_IDLE;
            tx_shift_q <= '0;
            tx_chan_q  <= '0;
            tx_cnt_q   <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_shift_q <= tx_shift_d;
            tx_chan_q  <= tx_chan_d;
            tx_cnt_q   <= tx_cnt_d;
        end
    end

    // ---------------- RX: collect tagged beats, validate, deliver ----------------
    rx_state_e                                 rx_state_q, rx_state_d;
    logic [beats_lp-1:0][fifo_width_p-1:0]     rx_buf_q, rx_buf_d;
    logic [cnt_width_lp-1:0]                   rx_cnt_q, rx_cnt_d;
    logic [chan_width_lp-1:0]                  rx_chan_q, rx_chan_d;
    logic                                      rx_rdy_q, rx_rdy_d;
    logic                                      rx_err_q, rx_err_d;
    logic                                      rx_fire, rx_first, rx_bad, rx_drop, rx_done;

    assign rx_fire  = rx_rdy_q && rx_v_i && (rx_state_q == R_COLLECT);
    assign rx_first = (rx_cnt_q == '0);
    assign rx_bad   = (rx_last_i != (rx_cnt_q == last_cnt_lp))
                   || (!rx_first && (rx_chan_i != rx_chan_q))
                   || (int'(rx_chan_i) >= num_chan_p);
    assign rx_drop  = rx_fire && rx_bad;
    assign rx_done  = (rx_state_q == R_DELIVER) && rec_rdy_i[rx_chan_q];

    always_comb begin
        rx_state_d = rx_state_q;
        rx_buf_d   = rx_buf_q;
        rx_cnt_d   = rx_cnt_q;
        rx_chan_d  = rx_chan_q;
        rx_err_d   = 1'b0;
        unique case (rx_state_q)
            R_COLLECT: begin
                if (rx_drop) begin
                    rx_err_d = 1'b1;
                    rx_cnt_d = '0;
                end else if (rx_fire) begin
                    rx_buf_d[rx_cnt_q] = rx_data_i;
                    if (rx_first) begin
                        rx_chan_d = rx_chan_i;
                    end
                    if (rx_last_i) begin
                        rx_cnt_d   = '0;
                        rx_state_d = R_DELIVER;
                    end else begin
                        rx_cnt_d = rx_cnt_q + 1'b1;
                    end
                end
            end
            R_DELIVER: begin
                if (rx_done) begin
                    rx_state_d = R_COLLECT;
                end
            end
            default: ;
        endcase
        // Registered so ready stays low while reset is held and drops the cycle after the final beat.
        rx_rdy_d = (rx_state_d == R_COLLECT);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rx_state_q <= R_COLLECT;
            rx_buf_q   <= '0;
            rx_cnt_q   <= '0;
            rx_chan_q  <= '0;
            rx_rdy_q   <= 1'b0;
            rx_err_q   <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_buf_q   <= rx_buf_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_chan_q  <= rx_chan_d;
            rx_rdy_q   <= rx_rdy_d;
            rx_err_q   <= rx_err_d;
        end
    end

    assign rx_rdy_o   = rx_rdy_q;
    assign rx_err_o   = rx_err_q;
    assign rec_data_o = rx_buf_q;

    always_comb begin
        rec_v_o = '0;
        for (int i = 0; i < num_chan_p; i++) begin
            rec_v_o[i] = (rx_state_q == R_DELIVER) && (int'(rx_chan_q) == i);
        end
    end

`ifdef BSG_MCL_SERDES_STATS_EN
    logic [31:0] tx_rec_cnt_q, tx_rec_cnt_d;
    logic [31:0] rx_rec_cnt_q, rx_rec_cnt_d;
    logic [15:0] rx_err_cnt_q, rx_err_cnt_d;

    // Counters stick at all-ones instead of wrapping.
    always_comb begin
        tx_rec_cnt_d = tx_rec_cnt_q;
        rx_rec_cnt_d = rx_rec_cnt_q;
        rx_err_cnt_d = rx_err_cnt_q;
        if (tx_done && !(&tx_rec_cnt_q)) tx_rec_cnt_d = tx_rec_cnt_q + 32'd1;
        if (rx_done && !(&rx_rec_cnt_q)) rx_rec_cnt_d = rx_rec_cnt_q + 32'd1;
        if (rx_drop && !(&rx_err_cnt_q)) rx_err_cnt_d = rx_err_cnt_q + 16'd1;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            tx_rec_cnt_q <= '0;
            rx_rec_cnt_q <= '0;
            rx_err_cnt_q <= '0;
        end else begin
            tx_rec_cnt_q <= tx_rec_cnt_d;
            rx_rec_cnt_q <= rx_rec_cnt_d;
            rx_err_cnt_q <= rx_err_cnt_d;
        end
    end

    assign tx_rec_count_o = tx_rec_cnt_q;
    assign rx_rec_count_o = rx_rec_cnt_q;
    assign rx_err_count_o = rx_err_cnt_q;
`endif

endmodule
